// File: rtl/alu_pkg.sv
// Shared types for the ALU command stage: opcodes, FSM states and the buffered command word.
package alu_pkg;

   localparam int ALU_W = 8;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_AND = 2'b10;
   localparam logic [1:0] OP_OR  = 2'b11;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      ISSUE = 2'b01,
      RESP  = 2'b10
   } state_t;

   typedef struct packed {
      logic [ALU_W-1:0] a;
      logic [ALU_W-1:0] b;
      logic [1:0]       op;
   } alu_cmd_t;

endpackage

// File: rtl/alu_cmd_stage_if.sv
// Command and response handshakes of the ALU command stage.
// master = upstream/downstream environment, slave = the stage itself.
interface alu_cmd_stage_if #(
   parameter int DATA_W = 8
);
   logic              cmd_valid;
   logic              cmd_ready;
   logic [DATA_W-1:0] cmd_a;
   logic [DATA_W-1:0] cmd_b;
   logic [1:0]        cmd_op;

   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_result;
   logic [1:0]        rsp_op;
   logic              rsp_zero;

   modport master (
      output cmd_valid, cmd_a, cmd_b, cmd_op, rsp_ready,
      input  cmd_ready, rsp_valid, rsp_result, rsp_op, rsp_zero
   );

   modport slave (
      input  cmd_valid, cmd_a, cmd_b, cmd_op, rsp_ready,
      output cmd_ready, rsp_valid, rsp_result, rsp_op, rsp_zero
   );
endinterface

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO; head entry is visible combinationally on rdata_o.
module alu_cmd_fifo
   import alu_pkg::*;
#(
   parameter  int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push_i,
   input  alu_cmd_t         wdata_i,
   input  logic             pop_i,
   output alu_cmd_t         rdata_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [CNT_W-1:0] count_o
);

   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   alu_cmd_t         mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic             wr_en;
   logic             rd_en;

   assign full_o  = (count_q == FULL_CNT);
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign rdata_o = mem_q[rd_ptr_q];

   // Guard internally as well so a stray request can never corrupt the pointers.
   assign wr_en = push_i && !full_o;
   assign rd_en = pop_i && !empty_o;

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_ptr_q] <= wdata_i;
      end
   end

   // Power-of-two depth: pointers wrap by natural overflow.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (wr_en) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (rd_en) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         case ({wr_en, rd_en})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/alu_cmd_stage.sv
// Command front-end / result back-end for the external 8-bit ALU.
//
//   state | meaning
//   IDLE  | nothing in flight, waiting for a buffered command
//   ISSUE | operands on alu_*, ALU settling; result captured at next edge
//   RESP  | response presented, held until rsp_ready
module alu_cmd_stage
   import alu_pkg::*;
#(
   parameter  int DATA_W = ALU_W,
   parameter  int DEPTH  = 4,
   localparam int CNT_W  = $clog2(DEPTH + 1)
) (
   input  logic               clk,
   input  logic               rst_n,
   alu_cmd_stage_if.slave     io,
   output logic [DATA_W-1:0]  alu_a,
   output logic [DATA_W-1:0]  alu_b,
   output logic [1:0]         alu_op,
   input  logic [DATA_W-1:0]  alu_result,
   output logic [CNT_W-1:0]   count
);

   state_t            state_q;
   logic [DATA_W-1:0] alu_a_q;
   logic [DATA_W-1:0] alu_b_q;
   logic [1:0]        alu_op_q;
   logic              rsp_valid_q;
   logic [DATA_W-1:0] rsp_result_q;
   logic [1:0]        rsp_op_q;
   logic              rsp_zero_q;

   alu_cmd_t          push_data;
   alu_cmd_t          head;
   logic              fifo_full;
   logic              fifo_empty;
   logic              push;
   logic              pop;

   assign push_data = '{a: io.cmd_a, b: io.cmd_b, op: io.cmd_op};
   assign push      = io.cmd_valid && !fifo_full;
   assign pop       = !fifo_empty &&
                      ((state_q == IDLE) || ((state_q == RESP) && io.rsp_ready));

   alu_cmd_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push),
      .wdata_i (push_data),
      .pop_i   (pop),
      .rdata_o (head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (count)
   );

   assign io.cmd_ready  = !fifo_full;
   assign io.rsp_valid  = rsp_valid_q;
   assign io.rsp_result = rsp_result_q;
   assign io.rsp_op     = rsp_op_q;
   assign io.rsp_zero   = rsp_zero_q;
   assign alu_a         = alu_a_q;
   assign alu_b         = alu_b_q;
   assign alu_op        = alu_op_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         alu_a_q      <= '0;
         alu_b_q      <= '0;
         alu_op_q     <= OP_ADD;
         rsp_valid_q  <= 1'b0;
         rsp_result_q <= '0;
         rsp_op_q     <= OP_ADD;
         rsp_zero_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (pop) begin
                  alu_a_q  <= head.a;
                  alu_b_q  <= head.b;
                  alu_op_q <= head.op;
                  state_q  <= ISSUE;
               end
            end
            ISSUE: begin
               rsp_result_q <= alu_result;
               rsp_op_q     <= alu_op_q;
               rsp_zero_q   <= (alu_result == '0);
               rsp_valid_q  <= 1'b1;
               state_q      <= RESP;
            end
            RESP: begin
               if (io.rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  // Chain straight into the next command when one is waiting.
                  if (pop) begin
                     alu_a_q  <= head.a;
                     alu_b_q  <= head.b;
                     alu_op_q <= head.op;
                     state_q  <= ISSUE;
                  end else begin
                     state_q  <= IDLE;
                  end
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_cmd_stage.sv
// Directed bench for alu_cmd_stage with a behavioural ALU next to the stage.
module tb_alu_cmd_stage;
   import alu_pkg::*;

   logic       clk;
   logic       rst_n;
   logic [7:0] alu_a;
   logic [7:0] alu_b;
   logic [1:0] alu_op;
   logic [7:0] alu_result;
   logic [2:0] count;

   int checks   = 0;
   int failures = 0;

   alu_cmd_stage_if #(.DATA_W(8)) bus ();

   alu_cmd_stage #(
      .DATA_W (8),
      .DEPTH  (4)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .io         (bus.slave),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_op     (alu_op),
      .alu_result (alu_result),
      .count      (count)
   );

   // external ALU
   always_comb begin
      alu_result = '0;
      case (alu_op)
         OP_ADD:  alu_result = alu_a + alu_b;
         OP_SUB:  alu_result = alu_a - alu_b;
         OP_AND:  alu_result = alu_a & alu_b;
         default: alu_result = alu_a | alu_b;
      endcase
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: obs=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: obs=0x%0h exp=0x%0h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge following the accepting edge.
   task automatic push_cmd(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
      int n = 0;
      bus.cmd_valid = 1'b1;
      bus.cmd_a     = a;
      bus.cmd_b     = b;
      bus.cmd_op    = op;
      while (!bus.cmd_ready && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (n >= 40) check_val("push_timeout", 32'(n), 0);
      @(negedge clk);
      bus.cmd_valid = 1'b0;
   endtask

   // Waits for a response, checks it, then consumes it with rsp_ready high.
   task automatic expect_rsp(input string tag, input logic [7:0] res,
                             input logic [1:0] op, input logic zero);
      int n = 0;
      while (!bus.rsp_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      check_val({tag, "_valid"},  32'(bus.rsp_valid),  1);
      check_val({tag, "_result"}, 32'(bus.rsp_result), 32'(res));
      check_val({tag, "_op"},     32'(bus.rsp_op),     32'(op));
      check_val({tag, "_zero"},   32'(bus.rsp_zero),   32'(zero));
      bus.rsp_ready = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      bit seen;
      rst_n         = 1'b0;
      bus.cmd_valid = 1'b0;
      bus.cmd_a     = '0;
      bus.cmd_b     = '0;
      bus.cmd_op    = '0;
      bus.rsp_ready = 1'b0;
      #1;
      check_val("rst_cmd_ready", 32'(bus.cmd_ready),  1);
      check_val("rst_count",     32'(count),          0);
      check_val("rst_rsp_valid", 32'(bus.rsp_valid),  0);
      check_val("rst_rsp_res",   32'(bus.rsp_result), 0);
      check_val("rst_alu_a",     32'(alu_a),          0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // latency: accept E0, issue E1, valid after E2
      bus.rsp_ready = 1'b1;
      push_cmd(8'h05, 8'h03, OP_ADD);
      check_val("lat_e0_valid", 32'(bus.rsp_valid), 0);
      @(negedge clk);
      check_val("lat_e1_valid", 32'(bus.rsp_valid), 0);
      check_val("lat_e1_alu_a", 32'(alu_a), 32'h05);
      check_val("lat_e1_alu_b", 32'(alu_b), 32'h03);
      @(negedge clk);
      check_val("lat_e2_valid", 32'(bus.rsp_valid),  1);
      check_val("lat_e2_res",   32'(bus.rsp_result), 32'h08);
      check_val("lat_e2_op",    32'(bus.rsp_op),     0);
      check_val("lat_e2_zero",  32'(bus.rsp_zero),   0);
      @(negedge clk);
      check_val("lat_e3_valid", 32'(bus.rsp_valid), 0);

      // wraparound and zero flag
      push_cmd(8'h03, 8'h05, OP_SUB);
      expect_rsp("sub_wrap", 8'hFE, OP_SUB, 1'b0);
      push_cmd(8'hFF, 8'h01, OP_ADD);
      expect_rsp("add_zero", 8'h00, OP_ADD, 1'b1);

      // backpressure: fill FIFO behind a held response
      bus.rsp_ready = 1'b0;
      push_cmd(8'h01, 8'h01, OP_ADD);
      push_cmd(8'h10, 8'h01, OP_SUB);
      push_cmd(8'h0C, 8'h0A, OP_AND);
      push_cmd(8'h0C, 8'h03, OP_OR);
      push_cmd(8'h80, 8'h80, OP_ADD);
      check_val("bp_count_full", 32'(count),          4);
      check_val("bp_cmd_ready",  32'(bus.cmd_ready),  0);
      check_val("bp_head_valid", 32'(bus.rsp_valid),  1);
      check_val("bp_head_res",   32'(bus.rsp_result), 32'h02);
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      check_val("bp_ready_back", 32'(bus.cmd_ready), 1);
      check_val("bp_count_3",    32'(count),         3);
      expect_rsp("bp_r2", 8'h0F, OP_SUB, 1'b0);
      expect_rsp("bp_r3", 8'h08, OP_AND, 1'b0);
      expect_rsp("bp_r4", 8'h0F, OP_OR,  1'b0);
      expect_rsp("bp_r5", 8'h00, OP_ADD, 1'b1);

      // logic ops and stability during a 3-cycle stall
      bus.rsp_ready = 1'b0;
      push_cmd(8'hF0, 8'h3C, OP_AND);
      push_cmd(8'hF0, 8'h0F, OP_OR);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_val($sformatf("stall%0d_valid", i), 32'(bus.rsp_valid),  1);
         check_val($sformatf("stall%0d_res", i),   32'(bus.rsp_result), 32'h30);
         check_val($sformatf("stall%0d_op", i),    32'(bus.rsp_op),     32'(OP_AND));
      end
      expect_rsp("and_rsp", 8'h30, OP_AND, 1'b0);
      expect_rsp("or_rsp",  8'hFF, OP_OR,  1'b0);
      @(negedge clk);

      // reset while in ISSUE with two entries buffered
      bus.rsp_ready = 1'b0;
      push_cmd(8'h12, 8'h34, OP_ADD);
      push_cmd(8'h9A, 8'h0A, OP_SUB);
      push_cmd(8'h55, 8'h0F, OP_AND);
      push_cmd(8'h66, 8'h01, OP_OR);
      check_val("rm_count_3", 32'(count), 3);
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      check_val("rm_issue_count", 32'(count),         2);
      check_val("rm_issue_valid", 32'(bus.rsp_valid), 0);
      check_val("rm_issue_alu_a", 32'(alu_a),         32'h9A);
      rst_n = 1'b0;
      #1;
      check_val("rm_count",     32'(count),          0);
      check_val("rm_cmd_ready", 32'(bus.cmd_ready),  1);
      check_val("rm_rsp_valid", 32'(bus.rsp_valid),  0);
      check_val("rm_rsp_res",   32'(bus.rsp_result), 0);
      check_val("rm_rsp_op",    32'(bus.rsp_op),     0);
      check_val("rm_rsp_zero",  32'(bus.rsp_zero),   0);
      check_val("rm_alu_a",     32'(alu_a),          0);
      check_val("rm_alu_b",     32'(alu_b),          0);
      check_val("rm_alu_op",    32'(alu_op),         0);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (bus.rsp_valid || count != 0) seen = 1'b1;
      end
      check_val("rm_no_stale", 32'(seen), 0);

      // simultaneous push and pop at count=2
      bus.rsp_ready = 1'b0;
      push_cmd(8'h11, 8'h22, OP_ADD);
      push_cmd(8'h50, 8'h20, OP_SUB);
      push_cmd(8'hAA, 8'h0F, OP_AND);
      check_val("pp_count_2",  32'(count),          2);
      check_val("pp_head_res", 32'(bus.rsp_result), 32'h33);
      bus.rsp_ready = 1'b1;
      push_cmd(8'hA0, 8'h05, OP_OR);
      check_val("pp_count_kept", 32'(count), 2);
      expect_rsp("pp_r2", 8'h30, OP_SUB, 1'b0);
      expect_rsp("pp_r3", 8'h0A, OP_AND, 1'b0);
      expect_rsp("pp_r4", 8'hA5, OP_OR,  1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/alu_cmd_stage.md
Name: alu_cmd_stage

Overview:
Command front-end and result back-end for the team's 8-bit combinational ALU (ports a, b, op, result).
- Accepts operand/opcode commands over a valid/ready interface and buffers them in a small FIFO.
- Issues one command at a time to the ALU through registered operand outputs.
- Captures the ALU result and presents it downstream over a valid/ready interface, with a zero flag.

Parameters:
- DATA_W, 8, operand/result width; must match the ALU width.
- DEPTH, 4, command FIFO entries; power of two, ≥2.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous assert, active-low.
- cmd_valid  input  1  upstream command valid.
- cmd_ready  output  1  stage can accept a command.
- cmd_a  input  DATA_W  operand A.
- cmd_b  input  DATA_W  operand B.
- cmd_op  input  2  opcode: 00 add, 01 sub, 10 and, 11 or.
- alu_a  output  DATA_W  registered operand A to the ALU a input.
- alu_b  output  DATA_W  registered operand B to the ALU b input.
- alu_op  output  2  registered opcode to the ALU op input.
- alu_result  input  DATA_W  combinational result from the ALU.
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  downstream accepts the response.
- rsp_result  output  DATA_W  captured ALU result.
- rsp_op  output  2  opcode that produced rsp_result.
- rsp_zero  output  1  high when rsp_result == 0.
- count  output  $clog2(DEPTH+1)  current FIFO occupancy.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE, FIFO empty, count=0.
  - alu_a, alu_b, alu_op = 0.
  - rsp_valid=0, rsp_result=0, rsp_op=0, rsp_zero=0.
  - cmd_ready follows !full, so it reads 1 during reset.
- Reset mid-operation discards all buffered and in-flight commands; no response is emitted for them.
- Push: on an edge with cmd_valid && cmd_ready, write {cmd_a, cmd_b, cmd_op} at the write pointer.
- cmd_ready = (count != DEPTH). There is no pop-bypass when full.
- Pointers wrap modulo DEPTH. count is updated +1 on push, −1 on pop, unchanged on simultaneous push+pop.
- FSM states: IDLE, ISSUE, RESP.
  - IDLE: if count != 0 at the edge: pop the head, load alu_a/alu_b/alu_op from it, go to ISSUE. Else stay in IDLE.
  - ISSUE (exactly 1 cycle; the ALU settles combinationally):
    - At the next edge: rsp_result<=alu_result, rsp_op<=alu_op, rsp_zero<=(alu_result==0), rsp_valid<=1.
    - Go to RESP.
  - RESP: hold all rsp_* stable while rsp_valid && !rsp_ready. On an edge with rsp_ready:
    - if count != 0: pop, load the ALU regs, go to ISSUE, rsp_valid<=0.
    - else: go to IDLE, rsp_valid<=0.
- alu_* keep their last value outside ISSUE; they are not cleared.
- A push into an empty FIFO is not visible to IDLE until the following edge, so there is no bypass path.
- Latency: accept edge E0 → pop/issue at E1 → rsp_valid high after E2 (2 cycles).
- Throughput: at most 1 response per 2 cycles with rsp_ready held high.
- Arithmetic: performed only by the external ALU. Add and sub wrap modulo 2^DATA_W; no carry or borrow is reported.
- Ordering: responses appear in strict command-acceptance order.
- A push and a pop on the same edge (including while in RESP) are both honoured.

Decomposition:
- Package alu_pkg:
  - opcode localparams OP_ADD=2'b00, OP_SUB=2'b01, OP_AND=2'b10, OP_OR=2'b11.
  - state enum {IDLE, ISSUE, RESP}.
  - packed struct alu_cmd_t {a, b, op}.
- Sub-module alu_cmd_fifo: synchronous FIFO of alu_cmd_t with push/pop/full/empty/count, parameterised by DEPTH.
- The FSM and response registers stay in alu_cmd_stage.
- The ALU is instantiated alongside this stage, not inside it.

Test Plan:
- Push {a=0x05, b=0x03, op=00}, rsp_ready=1 → rsp_valid high 2 cycles after accept, rsp_result=0x08, rsp_op=00, rsp_zero=0.
- Push {0x03, 0x05, op=01} → rsp_result=0xFE (wrap). Push {0xFF, 0x01, op=00} → rsp_result=0x00, rsp_zero=1.
- Hold rsp_ready=0 and push 5 commands back-to-back:
  - count reaches 4 (one command in RESP, 4 buffered) and cmd_ready=0.
  - Release rsp_ready → responses in order, cmd_ready returns 1 after the first pop.
- Push {0xF0, 0x3C, op=10} then {0xF0, 0x0F, op=11} → responses 0x30 then 0xFF, and rsp_* remain stable during a 3-cycle rsp_ready stall.
- Assert rst_n=0 while in ISSUE with 2 entries buffered:
  - all outputs return to reset values immediately and count=0.
  - no stale response appears after reset release.
- Simultaneous push and pop at count=2 → count stays 2, and the FIFO order of the next responses is preserved.
